// File: rtl/qtr.sv
// QTR-RC reflectance sensor reader: charges the sensor pin, then times the
// RC discharge in 10 us ticks and reports an 8-bit saturating count.
module qtr #(
  parameter int unsigned CLK_FREQUENCY = 60_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] value,
  output logic       valid,
  output logic       qtr_out_en,
  output logic       qtr_out_sig,
  input  logic       qtr_in_sig
);

  localparam int unsigned TickCycles = CLK_FREQUENCY / 100_000;
  localparam int unsigned CycW       = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(TickCycles - 1);
  localparam logic [7:0]      TickMax = 8'hff;

  typedef enum logic [1:0] {
    StIdle,
    StCharge,
    StMeasure,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [7:0]      tick_q, tick_d;
  logic [7:0]      result_q, result_d;
  logic [7:0]      value_q, value_d;
  logic            valid_q, valid_d;
  logic [1:0]      sync_q;
  logic            in_sync;
  logic            done;

  assign in_sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      tick_q   <= '0;
      result_q <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      tick_q   <= tick_d;
      result_q <= result_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      sync_q   <= {sync_q[0], qtr_in_sig};
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    tick_d   = tick_q;
    result_d = result_q;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StCharge;
          cyc_d   = '0;
          tick_d  = '0;
        end
      end
      StCharge: begin
        if (cyc_q == CycLast) begin
          cyc_d   = '0;
          state_d = StMeasure;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StMeasure: begin
        // Line low wins over timeout so a discharge on the last tick still reads its count.
        if (!in_sync) begin
          result_d = tick_q;
          state_d  = StDone;
        end else if (tick_q == TickMax) begin
          result_d = TickMax;
          state_d  = StDone;
        end else if (cyc_q == CycLast) begin
          cyc_d  = '0;
          tick_d = tick_q + 8'd1;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // value and valid are registered together so value only moves with the pulse.
  always_comb begin
    value_d = done ? result_q : value_q;
    valid_d = done;
  end

  assign value       = value_q;
  assign valid       = valid_q;
  assign qtr_out_en  = (state_q == StCharge);
  assign qtr_out_sig = (state_q == StCharge);

endmodule

// File: tb/tb_qtr.sv
// Directed bench for qtr at a 1 MHz clock (10 cycles per tick) so full
// timeouts stay short.
`timescale 1ns / 1ps
module tb_qtr;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] value;
  logic       valid;
  logic       qtr_out_en;
  logic       qtr_out_sig;
  logic       qtr_in_sig;

  int n_vec = 0;
  int n_err = 0;

  qtr #(
    .CLK_FREQUENCY(1_000_000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .value      (value),
    .valid      (valid),
    .qtr_out_en (qtr_out_en),
    .qtr_out_sig(qtr_out_sig),
    .qtr_in_sig (qtr_in_sig)
  );

  always #500 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // hi >= 0: line high for hi cycles after MEASURE entry, then low.
  // hi == -1: line low throughout. hi == -2: line stuck high.
  task automatic run_meas(input string tag, input int hi, input int exp_val,
                          input int exp_lat, input bit poke);
    int cnt;
    int lat;
    int oe_seen;
    qtr_in_sig = (hi != -1);
    en = 1'b1;
    step();
    check({tag, "_oe_lat"}, int'(qtr_out_en), 1);
    check({tag, "_sig_chg"}, int'(qtr_out_sig), 1);
    cnt = 0;
    while (qtr_out_en && cnt < 50) begin
      cnt++;
      en = (cnt == 1) || (poke && cnt == 5);
      step();
    end
    en = 1'b0;
    check({tag, "_charge_len"}, cnt, 10);
    if (hi >= 0) begin
      for (int i = 0; i < hi; i++) begin
        en = poke && (i == 3);
        step();
      end
      en = 1'b0;
      qtr_in_sig = 1'b0;
    end
    lat = 0;
    oe_seen = 0;
    while (!valid && lat < 3000) begin
      step();
      lat++;
      if (qtr_out_en) oe_seen++;
    end
    check({tag, "_valid_lat"}, lat, exp_lat);
    check({tag, "_oe_released"}, oe_seen, 0);
    check({tag, "_value"}, int'(value), exp_val);
    step();
    check({tag, "_valid_pulse"}, int'(valid), 0);
    oe_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (qtr_out_en || valid) oe_seen++;
    end
    check({tag, "_no_restart"}, oe_seen, 0);
    check({tag, "_value_hold"}, int'(value), exp_val);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    en = 1'b0;
    qtr_in_sig = 1'b0;
    repeat (3) step();
    check("rst_value", int'(value), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_oe", int'(qtr_out_en), 0);
    check("rst_sig", int'(qtr_out_sig), 0);
    reset = 1'b0;
    step();
    check("idle_oe", int'(qtr_out_en), 0);

    run_meas("t1ms", 998, 100, 4, 1'b0);
    run_meas("t500us", 500, 50, 4, 1'b0);
    run_meas("t_edge7", 7, 0, 4, 1'b0);
    run_meas("t_edge8_poke", 8, 1, 4, 1'b1);
    run_meas("t_low", -1, 0, 2, 1'b0);
    run_meas("t_stuck", -2, 255, 2552, 1'b0);

    // Abort mid-MEASURE: value must return to 0 and no pulse may follow.
    qtr_in_sig = 1'b1;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    repeat (9) step();
    check("mid_in_measure_oe", int'(qtr_out_en), 0);
    repeat (30) step();
    reset = 1'b1;
    step();
    check("mid_rst_value", int'(value), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_oe", int'(qtr_out_en), 0);
    check("mid_rst_sig", int'(qtr_out_sig), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid || qtr_out_en) seen++;
    end
    check("mid_rst_quiet", seen, 0);
    run_meas("t_after_rst", 48, 5, 4, 1'b0);

    // en held high restarts on the IDLE cycle right after the pulse.
    qtr_in_sig = 1'b0;
    en = 1'b1;
    seen = 0;
    while (!valid && seen < 50) begin
      step();
      seen++;
    end
    check("held_valid_lat", seen, 13);
    step();
    check("held_restart_oe", int'(qtr_out_en), 1);
    en = 1'b0;
    seen = 0;
    while (!valid && seen < 50) begin
      step();
      seen++;
    end
    check("held_second_lat", seen, 12);
    check("held_second_value", int'(value), 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
